trig_ctrl: RTL and testbench

//  Downstream of the per-channel trigger stages. ANDs the NUM_CH channel trigger terms with the protocol trigger.

---
 rtl/trig_ctrl.sv | 123 ++++++++++++
 tb/tb_trig_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_ctrl.sv
// Trigger qualification, sticky triggered flag and post-trigger sample counter.
// Optional build macro TRIG_DEBOUNCE_EN: the trigger condition must hold for DEB_CYC cycles.
module trig_ctrl #(
   parameter int NUM_CH  = 5,
   parameter int POS_W   = 9,
   parameter int DEB_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] chTrig,
   input  logic              protTrig,
   input  logic              armed,
   input  logic              wrt_smpl,
   input  logic [POS_W-1:0]  trig_pos,
   input  logic              set_capture_done,
   output logic              triggered,
   output logic              capture_done,
   output logic [POS_W-1:0]  post_cnt,
   output logic [1:0]        trig_state
);

   // state | meaning
   // IDLE  | not armed, post_cnt cleared
   // WAIT  | armed, waiting for a qualified trigger condition
   // POST  | triggered, counting post-trigger sample writes
   // DONE  | capture complete, waiting for set_capture_done
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_WAIT = 2'b01;
   localparam logic [1:0] S_POST = 2'b10;
   localparam logic [1:0] S_DONE = 2'b11;

   localparam logic [POS_W-1:0] CNT_MAX = '1;

   logic             cond;
   logic             qual;
   logic             fire;
   logic [POS_W-1:0] cnt_inc;
   logic             post_done;
   logic [1:0]       state_nxt;
   logic             trig_nxt;
   logic [POS_W-1:0] cnt_nxt;

   assign cond    = (&chTrig) & protTrig;
   assign qual    = (trig_state == S_WAIT) & armed & cond;
   assign cnt_inc = (post_cnt == CNT_MAX) ? post_cnt : post_cnt + 1'b1;

`ifdef TRIG_DEBOUNCE_EN
   localparam logic [3:0] DEB_LAST = 4'(DEB_CYC - 1);

   logic [3:0] deb_cnt;

   assign fire = qual & (deb_cnt == DEB_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         deb_cnt <= '0;
      else if (qual && !fire)
         deb_cnt <= deb_cnt + 1'b1;
      else
         deb_cnt <= '0;
   end
`else
   // DEB_CYC only matters with debounce; this term is 1 for every legal value.
   assign fire = qual & (DEB_CYC > 0);
`endif

   assign post_done = (trig_state == S_POST) &
                      ((trig_pos == '0) | (wrt_smpl & (cnt_inc == trig_pos)));

   always_comb begin
      state_nxt = trig_state;
      trig_nxt  = triggered;
      cnt_nxt   = post_cnt;
      case (trig_state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (armed)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!armed) begin
               state_nxt = S_IDLE;
            end else if (fire) begin
               state_nxt = S_POST;
               trig_nxt  = 1'b1;
               cnt_nxt   = '0;
            end
         end
         S_POST: begin
            if (trig_pos == '0) begin
               state_nxt = S_DONE;
            end else if (wrt_smpl) begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == trig_pos)
                  state_nxt = S_DONE;
            end
         end
         default: begin
         end
      endcase
      // Acknowledge wins over a simultaneous trigger or completion.
      if (set_capture_done) begin
         state_nxt = S_IDLE;
         trig_nxt  = 1'b0;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trig_state   <= S_IDLE;
         triggered    <= 1'b0;
         capture_done <= 1'b0;
         post_cnt     <= '0;
      end else begin
         trig_state   <= state_nxt;
         triggered    <= trig_nxt;
         capture_done <= post_done;
         post_cnt     <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_trig_ctrl.sv
// Directed self-checking bench for trig_ctrl; inputs change 1 time unit after the rising edge.
module tb_trig_ctrl;

`ifdef TRIG_DEBOUNCE_EN
   localparam int DEB     = 3;
   localparam int TRIG_LAT = 3;
`else
   localparam int DEB     = 2;
   localparam int TRIG_LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] chTrig;
   logic       protTrig;
   logic       armed;
   logic       wrt_smpl;
   logic [8:0] trig_pos;
   logic       set_capture_done;
   logic       triggered;
   logic       capture_done;
   logic [8:0] post_cnt;
   logic [1:0] trig_state;

   int n_chk  = 0;
   int n_fail = 0;

   trig_ctrl #(.NUM_CH(5), .POS_W(9), .DEB_CYC(DEB)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .chTrig           (chTrig),
      .protTrig         (protTrig),
      .armed            (armed),
      .wrt_smpl         (wrt_smpl),
      .trig_pos         (trig_pos),
      .set_capture_done (set_capture_done),
      .triggered        (triggered),
      .capture_done     (capture_done),
      .post_cnt         (post_cnt),
      .trig_state       (trig_state)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Arm from IDLE, raise the full trigger condition and wait until triggered is due.
   task automatic arm_and_trigger();
      armed    = 1'b1;
      chTrig   = 5'h1F;
      protTrig = 1'b1;
      tick(1);
      chk("arm_wait", trig_state, 2'b01);
      tick(TRIG_LAT);
   endtask

   task automatic ack();
      set_capture_done = 1'b1;
      armed            = 1'b0;
      tick(1);
      set_capture_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic saw_done;
      rst_n = 1'b0; chTrig = '0; protTrig = 1'b0; armed = 1'b0;
      wrt_smpl = 1'b0; trig_pos = 9'd4; set_capture_done = 1'b0;
      #12;
      chk("rst_trig", triggered, 1'b0);
      chk("rst_done", capture_done, 1'b0);
      chk("rst_cnt", post_cnt, 9'd0);
      chk("rst_state", trig_state, 2'b00);
      rst_n = 1'b1;
      tick(2);

      // basic capture, trig_pos = 4
      armed = 1'b1;
      tick(1);
      chk("t2_wait", trig_state, 2'b01);
      chTrig = 5'h1F; protTrig = 1'b1;
      tick(TRIG_LAT);
      chk("t2_trig", triggered, 1'b1);
      chk("t2_post", trig_state, 2'b10);
      chk("t2_cnt0", post_cnt, 9'd0);
      chTrig = 5'h00; wrt_smpl = 1'b1;
      tick(1); chk("t2_cnt1", post_cnt, 9'd1); chk("t2_nodone1", capture_done, 1'b0);
      tick(1); chk("t2_cnt2", post_cnt, 9'd2);
      tick(1); chk("t2_cnt3", post_cnt, 9'd3); chk("t2_nodone3", capture_done, 1'b0);
      tick(1);
      chk("t2_cnt4", post_cnt, 9'd4);
      chk("t2_done", capture_done, 1'b1);
      chk("t2_state_done", trig_state, 2'b11);
      tick(1);
      chk("t2_pulse_end", capture_done, 1'b0);
      chk("t2_cnt_hold", post_cnt, 9'd4);
      chk("t2_trig_hold", triggered, 1'b1);
      wrt_smpl = 1'b0;
      ack();
      chk("t5_ack_trig", triggered, 1'b0);
      chk("t5_ack_cnt", post_cnt, 9'd0);
      chk("t5_ack_state", trig_state, 2'b00);

      // qualification: one channel missing, protocol missing, not armed
      armed = 1'b1; chTrig = 5'h1E; protTrig = 1'b1;
      tick(101);
      chk("t3_ch_missing", triggered, 1'b0);
      chTrig = 5'h1F; protTrig = 1'b0;
      tick(100);
      chk("t3_prot_missing", triggered, 1'b0);
      chk("t3_still_wait", trig_state, 2'b01);
      armed = 1'b0; protTrig = 1'b1;
      tick(1);
      chk("t3_disarm_idle", trig_state, 2'b00);
      tick(100);
      chk("t3_unarmed", triggered, 1'b0);

      // trig_pos = 0: done one cycle after triggered
      trig_pos = 9'd0;
      arm_and_trigger();
      chk("t4_z_trig", triggered, 1'b1);
      chk("t4_z_nodone", capture_done, 1'b0);
      tick(1);
      chk("t4_z_done", capture_done, 1'b1);
      chk("t4_z_state", trig_state, 2'b11);
      chk("t4_z_cnt", post_cnt, 9'd0);
      ack();

      // trig_pos = 511 with continuous writes
      trig_pos = 9'd511;
      arm_and_trigger();
      chk("t4_m_trig", triggered, 1'b1);
      wrt_smpl = 1'b1;
      tick(510);
      chk("t4_m_cnt510", post_cnt, 9'd510);
      chk("t4_m_nodone", capture_done, 1'b0);
      tick(1);
      chk("t4_m_cnt511", post_cnt, 9'd511);
      chk("t4_m_done", capture_done, 1'b1);
      tick(1);
      chk("t4_m_nowrap", post_cnt, 9'd511);
      chk("t4_m_pulse_end", capture_done, 1'b0);
      wrt_smpl = 1'b0;
      ack();

      // acknowledge coinciding with the firing trigger
      trig_pos = 9'd4;
      armed = 1'b1; chTrig = 5'h1F; protTrig = 1'b1;
      tick(1);
      tick(TRIG_LAT - 1);
      set_capture_done = 1'b1;
      tick(1);
      set_capture_done = 1'b0; armed = 1'b0;
      chk("t5_sim_state", trig_state, 2'b00);
      chk("t5_sim_trig", triggered, 1'b0);
      tick(1);
      chk("t5_sim_trig2", triggered, 1'b0);

      // acknowledge coinciding with completion: pulse still issued, state IDLE
      trig_pos = 9'd1;
      arm_and_trigger();
      armed = 1'b0;
      wrt_smpl = 1'b1; set_capture_done = 1'b1;
      tick(1);
      wrt_smpl = 1'b0; set_capture_done = 1'b0;
      chk("t5_ackdone_pulse", capture_done, 1'b1);
      chk("t5_ackdone_state", trig_state, 2'b00);
      chk("t5_ackdone_trig", triggered, 1'b0);
      tick(1);

      // asynchronous reset mid-POST with post_cnt = 7
      trig_pos = 9'd20;
      arm_and_trigger();
      wrt_smpl = 1'b1;
      tick(7);
      chk("t1_cnt7", post_cnt, 9'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_rst_cnt", post_cnt, 9'd0);
      chk("t1_rst_trig", triggered, 1'b0);
      chk("t1_rst_state", trig_state, 2'b00);
      chk("t1_rst_done", capture_done, 1'b0);
      wrt_smpl = 1'b0; armed = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (capture_done) saw_done = 1'b1;
      end
      chk("t1_no_done_after", saw_done, 1'b0);

`ifdef TRIG_DEBOUNCE_EN
      // debounce with DEB_CYC = 3
      armed = 1'b1; chTrig = 5'h1F; protTrig = 1'b0;
      tick(1);
      protTrig = 1'b1;
      tick(2);
      protTrig = 1'b0;
      tick(3);
      chk("t6_short", triggered, 1'b0);
      protTrig = 1'b1;
      tick(2);
      chk("t6_not_yet", triggered, 1'b0);
      tick(1);
      chk("t6_fire", triggered, 1'b1);
      ack();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
